op_pipe_alu: RTL and testbench
==============================

// Module: op_pipe_alu
// PURPOSE
//  Parametrised, pipelined operator unit covering the expression classes of the DFG snippet set:
//  bitwise, arithmetic, shift, compare and reduction, plus optional div/mod.
//  Accepts one operation per cycle via valid/ready and returns it STAGES cycles later.
//  Sits as a registered datapath leaf; exercises the sequential, clocked paths of the conversion flow.
// PARAMETERS
//  WIDTH   8   operand/result width, >= 2
//  STAGES  3   pipeline register stages, >= 1; unstalled latency in cycles
//  SHW     $clog2(WIDTH)   shift-amount width (derived, do not override)
// PORTS
//  clk        in   1                  clock, all state on posedge
//  rst        in   1                  synchronous reset, active-high
//  in_valid   in   1                  operation offered
//  in_ready   out  1                  operation accepted when in_valid && in_ready
//  op         in   5                  operation code (table below)
//  a          in   WIDTH              operand A
//  b          in   WIDTH              operand B
//  shamt      in   SHW                shift amount
//  out_valid  out  1                  result present at final stage
//  out_ready  in   1                  consumer takes result when out_valid && out_ready
//  result     out  WIDTH              operation result
//  flag       out  1                  per-op status bit
//  occ        out  $clog2(STAGES+1)   number of valid stages in pipeline
// BEHAVIOUR
//  - Reset: all stage valids, out_valid, result, flag, occ = 0. in_ready forced 0 while rst is high.
//    Reset mid-operation flushes every in-flight op; no output for flushed ops.
//  - Global advance: adv = !out_valid || out_ready. in_ready = adv && !rst. When adv = 0, all stages hold.
//  - Bubbles do not collapse. Order is strictly preserved. No drop, no duplicate.
//  - Compute happens combinationally into stage 0. Stages 1..STAGES-1 only carry data.
//    Accepted op appears at out_valid after exactly STAGES cycles when unstalled.
//  - occ: +1 on accept, -1 on output handshake; unchanged when both occur in the same cycle.
//  - Op table (unsigned unless noted; results truncated to WIDTH):
//      0 ADD   a+b          flag = carry out
//      1 SUB   a-b          flag = borrow (a < b)
//      2 MUL   low half     flag = high half != 0
//      3 AND   a&b          flag = 0
//      4 OR    a|b          flag = 0
//      5 XOR   a^b          flag = 0
//      6 NOT   ~a           flag = 0
//      7 SHL   a<<shamt     flag = 0
//      8 SHR   a>>shamt     flag = 0
//      9 SRA   signed a>>>shamt   flag = 0
//     10 EQ    a==b         result = {0..,bit}, flag = bit
//     11 NE    a!=b         result = {0..,bit}, flag = bit
//     12 GT    a>b          result = {0..,bit}, flag = bit
//     13 RAND  &a           result = {0..,bit}, flag = bit
//     14 RXOR  ^a           result = {0..,bit}, flag = bit
//  - shamt >= WIDTH (non-power-of-2 WIDTH only): SHL/SHR give 0; SRA gives all copies of a[WIDTH-1].
//  - Unused or disabled op codes: result = 0, flag = 1 (illegal-op).
// CONFIGURATION
//  OP_PIPE_ALU_DIVMOD_EN defined:
//   - 16 DIV: result = a/b, flag = 0.
//   - 17 MOD: result = a%b, flag = 0.
//   - b == 0: DIV result = all ones, MOD result = a, flag = 1.
//  Macro undefined: no divider logic is built; codes 16/17 are illegal (result 0, flag 1).
//  Latency is identical in both builds.
// TESTING  (WIDTH=8, STAGES=3)
//  1 Release rst; ADD a=0xF0 b=0x20, out_ready=1 -> out_valid 3 cycles after accept;
//    result 0x10, flag 1; occ 1 then 0.
//  2 SRA a=0x80 shamt=3 -> 0xF0. SHR same operands -> 0x10. SUB a=0x01 b=0x02 -> 0xFF, flag 1.
//  3 Three back-to-back ops, then out_ready=0 for 4 cycles -> in_ready 0 while out_valid;
//    occ holds 3; all three drain in order once out_ready=1.
//  4 rst pulsed for 1 cycle with occ=2 -> next cycle out_valid 0, occ 0;
//    next op returns after exactly 3 cycles.
//  5 DIVMOD_EN build: DIV 0x64/0x07 -> 0x0E; MOD -> 0x02; DIV by 0 -> 0xFF, flag 1.
//    Plain build: op 16 -> 0x00, flag 1.
//  6 EQ a=b=0x5A -> 0x01, flag 1. RXOR a=0x07 -> 0x01. Op 20 -> 0x00, flag 1.

Source files
------------

// File: rtl/op_pipe_alu_if.sv
`default_nettype none
// ============================================================================
// Module     : op_pipe_alu_if
// Description: Operation/result handshake bundle for op_pipe_alu.
// Revision   : 1.0 - initial release
// ============================================================================
interface op_pipe_alu_if #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int OCCW = $clog2(STAGES + 1);

    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag;
    logic [OCCW-1:0]  occ;

    modport master (
        output in_valid, op, a, b, shamt, out_ready,
        input  in_ready, out_valid, result, flag, occ
    );

    modport slave (
        input  in_valid, op, a, b, shamt, out_ready,
        output in_ready, out_valid, result, flag, occ
    );
endinterface
`default_nettype wire

// File: rtl/op_pipe_alu.sv
`default_nettype none
// ============================================================================
// Module     : op_pipe_alu
// Description: Pipelined operator unit (bitwise/arith/shift/compare/reduce),
//              one op per cycle, STAGES-cycle latency, global stall.
//              Define OP_PIPE_ALU_DIVMOD_EN to build the DIV/MOD ops.
// Revision   : 1.0 - initial release
// ============================================================================
module op_pipe_alu #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3
) (
    input  logic         clk,
    input  logic         rst,
    op_pipe_alu_if.slave bus
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int OCCW = $clog2(STAGES + 1);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_NOT  = 5'd6;
    localparam logic [4:0] OP_SHL  = 5'd7;
    localparam logic [4:0] OP_SHR  = 5'd8;
    localparam logic [4:0] OP_SRA  = 5'd9;
    localparam logic [4:0] OP_EQ   = 5'd10;
    localparam logic [4:0] OP_NE   = 5'd11;
    localparam logic [4:0] OP_GT   = 5'd12;
    localparam logic [4:0] OP_RAND = 5'd13;
    localparam logic [4:0] OP_RXOR = 5'd14;
`ifdef OP_PIPE_ALU_DIVMOD_EN
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_MOD  = 5'd17;
`endif

    logic                 adv;
    logic                 accept;
    logic                 take;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     sra_val;
    logic                 over_shift;
    logic [WIDTH-1:0]     calc_res;
    logic                 calc_flag;
    logic [STAGES-1:0]    vld;
    logic [STAGES-1:0]    flg;
    logic [WIDTH-1:0]     res [STAGES];
    logic [OCCW-1:0]      occ_cnt;

    assign adv          = !vld[STAGES-1] || bus.out_ready;
    assign bus.in_ready = adv && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign take         = vld[STAGES-1] && bus.out_ready;

    assign bus.out_valid = vld[STAGES-1];
    assign bus.result    = res[STAGES-1];
    assign bus.flag      = flg[STAGES-1];
    assign bus.occ       = occ_cnt;

    assign sum     = {1'b0, bus.a} + {1'b0, bus.b};
    assign prod    = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
    assign sra_val = $unsigned($signed(bus.a) >>> bus.shamt);

    // Only a non-power-of-2 width can see a shift amount past the operand.
    generate
        if ((1 << SHW) != WIDTH) begin : g_shift_clamp
            assign over_shift = bus.shamt >= SHW'(WIDTH);
        end else begin : g_shift_full
            assign over_shift = 1'b0;
        end
    endgenerate

`ifdef OP_PIPE_ALU_DIVMOD_EN
    logic             b_zero;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    assign b_zero = (bus.b == '0);
    assign quo    = b_zero ? '1    : bus.a / bus.b;
    assign rem    = b_zero ? bus.a : bus.a % bus.b;
`endif

    always_comb begin
        calc_res  = '0;
        calc_flag = 1'b0;
        case (bus.op)
            OP_ADD:  begin calc_res = sum[WIDTH-1:0];  calc_flag = sum[WIDTH];              end
            OP_SUB:  begin calc_res = bus.a - bus.b;   calc_flag = bus.a < bus.b;           end
            OP_MUL:  begin calc_res = prod[WIDTH-1:0]; calc_flag = |prod[2*WIDTH-1:WIDTH];  end
            OP_AND:  calc_res = bus.a & bus.b;
            OP_OR:   calc_res = bus.a | bus.b;
            OP_XOR:  calc_res = bus.a ^ bus.b;
            OP_NOT:  calc_res = ~bus.a;
            OP_SHL:  calc_res = over_shift ? '0 : bus.a << bus.shamt;
            OP_SHR:  calc_res = over_shift ? '0 : bus.a >> bus.shamt;
            OP_SRA:  calc_res = over_shift ? {WIDTH{bus.a[WIDTH-1]}} : sra_val;
            OP_EQ:   begin calc_res[0] = (bus.a == bus.b); calc_flag = calc_res[0]; end
            OP_NE:   begin calc_res[0] = (bus.a != bus.b); calc_flag = calc_res[0]; end
            OP_GT:   begin calc_res[0] = (bus.a >  bus.b); calc_flag = calc_res[0]; end
            OP_RAND: begin calc_res[0] = &bus.a;           calc_flag = calc_res[0]; end
            OP_RXOR: begin calc_res[0] = ^bus.a;           calc_flag = calc_res[0]; end
`ifdef OP_PIPE_ALU_DIVMOD_EN
            OP_DIV:  begin calc_res = quo; calc_flag = b_zero; end
            OP_MOD:  begin calc_res = rem; calc_flag = b_zero; end
`endif
            default: calc_flag = 1'b1;
        endcase
    end

    // Bubbles travel with the pipe; payload is only captured on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            flg <= '0;
            for (int i = 0; i < STAGES; i++) begin
                res[i] <= '0;
            end
        end else if (adv) begin
            vld[0] <= accept;
            if (accept) begin
                res[0] <= calc_res;
                flg[0] <= calc_flag;
            end
            for (int i = 1; i < STAGES; i++) begin
                vld[i] <= vld[i-1];
                res[i] <= res[i-1];
                flg[i] <= flg[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_cnt <= '0;
        end else if (accept && !take) begin
            occ_cnt <= occ_cnt + OCCW'(1);
        end else if (take && !accept) begin
            occ_cnt <= occ_cnt - OCCW'(1);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_op_pipe_alu.sv
`default_nettype none
// ============================================================================
// Module     : tb_op_pipe_alu
// Description: Scoreboard bench for op_pipe_alu (WIDTH=8, STAGES=3).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_op_pipe_alu;
    localparam int LAT = 3;

    typedef struct {
        logic [7:0] res;
        logic       flg;
        int         acc;
        bit         lat;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    op_pipe_alu_if #(.WIDTH(8), .STAGES(3)) bus ();
    op_pipe_alu #(.WIDTH(8), .STAGES(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, expv);
        end
    endtask

    task automatic issue(input logic [4:0] o, input logic [7:0] av, input logic [7:0] bv,
                         input logic [2:0] sh, input logic [7:0] er, input logic ef,
                         input bit lat, input string nm);
        exp_t e;
        int   n;
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.a        = av;
        bus.b        = bv;
        bus.shamt    = sh;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout_%s actual=in_ready0 required=in_ready1", nm);
        end else begin
            e.res = er; e.flg = ef; e.acc = cyc; e.lat = lat; e.name = nm;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.occ != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0 || bus.occ != 0) begin
            failures++;
            $display("FAIL drain_%s actual=pending%0d_occ%0d required=pending0_occ0",
                     nm, sb.size(), bus.occ);
        end
    endtask

    // Monitor: every output handshake is checked against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output actual=0x%0h/%0b required=none",
                             bus.result, bus.flag);
                end else begin
                    e = sb.pop_front();
                    if (bus.result !== e.res || bus.flag !== e.flg) begin
                        failures++;
                        $display("FAIL %s actual=0x%0h/%0b required=0x%0h/%0b",
                                 e.name, bus.result, bus.flag, e.res, e.flg);
                    end
                    if (e.lat) begin
                        checks++;
                        if (cyc - e.acc != LAT) begin
                            failures++;
                            $display("FAIL latency_%s actual=%0d required=%0d",
                                     e.name, cyc - e.acc, LAT);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.op = 5'd0; bus.a = 8'd0; bus.b = 8'd0; bus.shamt = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_occ", {30'd0, bus.occ}, 32'd0);
        chk("rst_result", {24'd0, bus.result}, 32'd0);
        chk("rst_flag", {31'd0, bus.flag}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single ADD with occupancy tracking
        issue(5'd0, 8'hF0, 8'h20, 3'd0, 8'h10, 1'b1, 1, "add_carry");
        chk("occ_after_accept", {30'd0, bus.occ}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("occ_after_output", {30'd0, bus.occ}, 32'd0);

        // Back-to-back directed op vectors
        issue(5'd9,  8'h80, 8'h00, 3'd3, 8'hF0, 1'b0, 1, "sra");
        issue(5'd8,  8'h80, 8'h00, 3'd3, 8'h10, 1'b0, 1, "shr");
        issue(5'd1,  8'h01, 8'h02, 3'd0, 8'hFF, 1'b1, 1, "sub_borrow");
        issue(5'd1,  8'h05, 8'h03, 3'd0, 8'h02, 1'b0, 1, "sub_plain");
        issue(5'd0,  8'h01, 8'h02, 3'd0, 8'h03, 1'b0, 1, "add_plain");
        issue(5'd2,  8'h10, 8'h10, 3'd0, 8'h00, 1'b1, 1, "mul_hi");
        issue(5'd2,  8'h03, 8'h05, 3'd0, 8'h0F, 1'b0, 1, "mul_lo");
        issue(5'd6,  8'h5A, 8'h00, 3'd0, 8'hA5, 1'b0, 1, "not");
        issue(5'd7,  8'h81, 8'h00, 3'd1, 8'h02, 1'b0, 1, "shl");
        issue(5'd10, 8'h5A, 8'h5A, 3'd0, 8'h01, 1'b1, 1, "eq");
        issue(5'd11, 8'h5A, 8'h5A, 3'd0, 8'h00, 1'b0, 1, "ne");
        issue(5'd12, 8'h05, 8'h03, 3'd0, 8'h01, 1'b1, 1, "gt");
        issue(5'd13, 8'hFF, 8'h00, 3'd0, 8'h01, 1'b1, 1, "rand_one");
        issue(5'd13, 8'hFE, 8'h00, 3'd0, 8'h00, 1'b0, 1, "rand_zero");
        issue(5'd14, 8'h07, 8'h00, 3'd0, 8'h01, 1'b1, 1, "rxor");
        issue(5'd15, 8'h12, 8'h34, 3'd0, 8'h00, 1'b1, 1, "illegal15");
        issue(5'd20, 8'h12, 8'h34, 3'd0, 8'h00, 1'b1, 1, "illegal20");
`ifdef OP_PIPE_ALU_DIVMOD_EN
        issue(5'd16, 8'h64, 8'h07, 3'd0, 8'h0E, 1'b0, 1, "div");
        issue(5'd17, 8'h64, 8'h07, 3'd0, 8'h02, 1'b0, 1, "mod");
        issue(5'd16, 8'h64, 8'h00, 3'd0, 8'hFF, 1'b1, 1, "div_zero");
        issue(5'd17, 8'h64, 8'h00, 3'd0, 8'h64, 1'b1, 1, "mod_zero");
`else
        issue(5'd16, 8'h64, 8'h07, 3'd0, 8'h00, 1'b1, 1, "div_disabled");
        issue(5'd17, 8'h64, 8'h07, 3'd0, 8'h00, 1'b1, 1, "mod_disabled");
`endif
        drain("vectors");

        // Stall: pipe fills, holds, then drains in order
        bus.out_ready = 1'b0;
        issue(5'd3, 8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0, 0, "stall_and");
        issue(5'd4, 8'hF0, 8'h0F, 3'd0, 8'hFF, 1'b0, 0, "stall_or");
        issue(5'd5, 8'hFF, 8'h0F, 3'd0, 8'hF0, 1'b0, 0, "stall_xor");
        chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("stall_occ_full", {30'd0, bus.occ}, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        chk("stall_occ_hold", {30'd0, bus.occ}, 32'd3);
        chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        drain("stall");

        // Reset flushes in-flight ops
        issue(5'd0, 8'h01, 8'h02, 3'd0, 8'h03, 1'b0, 0, "flushed_a");
        issue(5'd1, 8'h09, 8'h02, 3'd0, 8'h07, 1'b0, 0, "flushed_b");
        chk("flush_occ_before", {30'd0, bus.occ}, 32'd2);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_occ", {30'd0, bus.occ}, 32'd0);
        issue(5'd5, 8'hAA, 8'h0F, 3'd0, 8'hA5, 1'b0, 1, "post_reset_xor");
        drain("post_reset");
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
